// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, state types and parity helper for the UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int PARITY_NONE   = 0;
   localparam int PARITY_ODD    = 1;
   localparam int PARITY_EVEN   = 2;
   localparam int MAX_DATA_BITS = 16;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_e;

   // Only the low 'width' bits take part; the caller zero-extends its word.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input int width, input int mode);
      logic x;
      x = 1'b0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < width) x = x ^ data[i];
      end
      if (mode == PARITY_EVEN) return x;
      if (mode == PARITY_ODD)  return ~x;
      return 1'b0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter; tick_o is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             tick_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (count_q != '0)
         count_d = count_q - WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign tick_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_driver_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_driver_cfg
// Description : Full-duplex UART with configurable parity, stop bits and RX sync.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_driver_cfg
   import uart_pkg::*;
#(
   parameter int BIT_DURATION  = 104,
   parameter int NUM_DATA_BITS = 8,
   parameter int PARITY_MODE   = 0,
   parameter int NUM_STOP_BITS = 1,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     tx_start,
   input  logic [NUM_DATA_BITS-1:0] tx_data,
   output logic                     tx_ready,
   output logic                     tx_out,
   input  logic                     rx_in,
   output logic [NUM_DATA_BITS-1:0] rx_data,
   output logic                     rx_new_data,
   output logic                     rx_parity_err,
   output logic                     rx_frame_err
);

   if (BIT_DURATION < 8 || NUM_DATA_BITS < 5 || NUM_DATA_BITS > MAX_DATA_BITS ||
       PARITY_MODE < 0 || PARITY_MODE > 2 ||
       (NUM_STOP_BITS != 1 && NUM_STOP_BITS != 2) || SYNC_STAGES < 2) begin : g_param_check
      $error("uart_driver_cfg: illegal parameter combination");
   end

   localparam int TW = $clog2(BIT_DURATION + 1);
   localparam int IW = $clog2(NUM_DATA_BITS + 1);
   localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_DURATION - 1);
   localparam logic [TW-1:0] HALF_LOAD  = TW'(BIT_DURATION / 2 - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DATA_BITS - 1);
   localparam logic          STOP_LAST  = (NUM_STOP_BITS == 2);
   localparam bit            HAS_PARITY = (PARITY_MODE != PARITY_NONE);

   // ---------------- TX ----------------
   tx_state_e               tx_state_q, tx_state_d;
   logic [NUM_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [IW-1:0]           tx_idx_q, tx_idx_d;
   logic                    tx_par_q, tx_par_d;
   logic                    tx_stop_q, tx_stop_d;
   logic                    tx_load, tx_tick;

   uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
      .clk_i(sys_clk), .rst_i(rst), .load_i(tx_load), .load_val_i(BIT_LOAD), .tick_o(tx_tick)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_idx_d   = tx_idx_q;
      tx_par_d   = tx_par_q;
      tx_stop_d  = tx_stop_q;
      tx_load    = 1'b0;
      tx_out     = 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_start) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data;
               tx_par_d   = calc_parity(MAX_DATA_BITS'(tx_data), NUM_DATA_BITS, PARITY_MODE);
               tx_idx_d   = '0;
               tx_stop_d  = 1'b0;
               tx_load    = 1'b1;
            end
         end
         TX_START: begin
            tx_out = 1'b0;
            if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_load    = 1'b1;
            end
         end
         TX_DATA: begin
            tx_out = tx_shift_q[0];
            if (tx_tick) begin
               tx_load    = 1'b1;
               tx_shift_d = tx_shift_q >> 1;
               tx_idx_d   = tx_idx_q + IW'(1);
               if (tx_idx_q == LAST_IDX) tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
            end
         end
         TX_PARITY: begin
            tx_out = tx_par_q;
            if (tx_tick) begin
               tx_state_d = TX_STOP;
               tx_load    = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               if (tx_stop_q == STOP_LAST) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_stop_d = 1'b1;
                  tx_load   = 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_ready = (tx_state_q == TX_IDLE);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_idx_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_idx_q   <= tx_idx_d;
         tx_par_q   <= tx_par_d;
         tx_stop_q  <= tx_stop_d;
      end
   end

   // ---------------- RX ----------------
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     rx_s;
   rx_state_e                rx_state_q, rx_state_d;
   logic [NUM_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic [IW-1:0]            rx_idx_q, rx_idx_d;
   logic                     rx_par_q, rx_par_d;
   logic                     rx_stop_q, rx_stop_d;
   logic                     rx_armed_q, rx_armed_d;
   logic                     rx_facc_q, rx_facc_d;
   logic                     rx_new_q, rx_new_d;
   logic                     rx_perr_q, rx_perr_d;
   logic                     rx_ferr_q, rx_ferr_d;
   logic                     rx_load, rx_tick;
   logic [TW-1:0]            rx_load_val;

   assign rx_s = sync_q[SYNC_STAGES-1];

   uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
      .clk_i(sys_clk), .rst_i(rst), .load_i(rx_load), .load_val_i(rx_load_val), .tick_o(rx_tick)
   );

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_idx_d    = rx_idx_q;
      rx_par_d    = rx_par_q;
      rx_stop_d   = rx_stop_q;
      rx_armed_d  = rx_armed_q;
      rx_facc_d   = rx_facc_q;
      rx_new_d    = 1'b0;
      rx_perr_d   = rx_perr_q;
      rx_ferr_d   = rx_ferr_q;
      rx_load     = 1'b0;
      rx_load_val = BIT_LOAD;
      case (rx_state_q)
         RX_IDLE: begin
            // A falling edge only counts once the line has been seen idle-high.
            rx_armed_d = rx_armed_q | rx_s;
            if (rx_armed_q && !rx_s) begin
               rx_state_d  = RX_START;
               rx_load     = 1'b1;
               rx_load_val = HALF_LOAD;
               rx_idx_d    = '0;
               rx_stop_d   = 1'b0;
               rx_facc_d   = 1'b0;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               if (rx_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_load    = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_load    = 1'b1;
               rx_shift_d = {rx_s, rx_shift_q[NUM_DATA_BITS-1:1]};
               rx_idx_d   = rx_idx_q + IW'(1);
               if (rx_idx_q == LAST_IDX) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
            end
         end
         RX_PARITY: begin
            if (rx_tick) begin
               rx_par_d   = rx_s;
               rx_state_d = RX_STOP;
               rx_load    = 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               if (rx_stop_q == STOP_LAST) begin
                  rx_state_d = RX_IDLE;
                  rx_armed_d = 1'b0;
                  rx_new_d   = 1'b1;
                  rx_data_d  = rx_shift_q;
                  rx_ferr_d  = rx_facc_q | ~rx_s;
                  rx_perr_d  = HAS_PARITY ?
                     (rx_par_q != calc_parity(MAX_DATA_BITS'(rx_shift_q), NUM_DATA_BITS, PARITY_MODE))
                     : 1'b0;
               end else begin
                  rx_stop_d = 1'b1;
                  rx_facc_d = rx_facc_q | ~rx_s;
                  rx_load   = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '1;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_idx_q   <= '0;
         rx_par_q   <= 1'b0;
         rx_stop_q  <= 1'b0;
         rx_armed_q <= 1'b0;
         rx_facc_q  <= 1'b0;
         rx_new_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_in};
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_idx_q   <= rx_idx_d;
         rx_par_q   <= rx_par_d;
         rx_stop_q  <= rx_stop_d;
         rx_armed_q <= rx_armed_d;
         rx_facc_q  <= rx_facc_d;
         rx_new_q   <= rx_new_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_new_data   = rx_new_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_driver_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_driver_cfg
// Description : Directed self-checking bench: 8E1 instance and 12O2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_driver_cfg;

   localparam int BD = 104;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst6;
   logic        tx_start0, tx_ready0, tx_out0, rx0;
   logic [7:0]  tx_data0, rx_data0;
   logic        rx_new0, rx_perr0, rx_ferr0;
   logic        tx_start6, tx_ready6, tx_out6, rx6;
   logic [11:0] tx_data6, rx_data6;
   logic        rx_new6, rx_perr6, rx_ferr6;

   int checks = 0;
   int errors = 0;
   int strobes0 = 0;

   uart_driver_cfg #(.BIT_DURATION(BD), .NUM_DATA_BITS(8), .PARITY_MODE(2),
                     .NUM_STOP_BITS(1), .SYNC_STAGES(2)) dut (
      .sys_clk(clk), .rst(rst), .tx_start(tx_start0), .tx_data(tx_data0),
      .tx_ready(tx_ready0), .tx_out(tx_out0), .rx_in(rx0), .rx_data(rx_data0),
      .rx_new_data(rx_new0), .rx_parity_err(rx_perr0), .rx_frame_err(rx_ferr0)
   );

   uart_driver_cfg #(.BIT_DURATION(BD), .NUM_DATA_BITS(12), .PARITY_MODE(1),
                     .NUM_STOP_BITS(2), .SYNC_STAGES(3)) dut6 (
      .sys_clk(clk), .rst(rst6), .tx_start(tx_start6), .tx_data(tx_data6),
      .tx_ready(tx_ready6), .tx_out(tx_out6), .rx_in(rx6), .rx_data(rx_data6),
      .rx_new_data(rx_new6), .rx_parity_err(rx_perr6), .rx_frame_err(rx_ferr6)
   );

   always @(negedge clk) if (rx_new0 === 1'b1) strobes0 <= strobes0 + 1;

   // Sends one word on the selected instance and checks every bit period.
   task automatic tx_check(input int sel, input logic [15:0] d, input int nb, input int pm,
                           input int ns, input bit inject, input string name);
      logic [19:0] frame;
      logic x, o, r, act;
      bit bad, rbad;
      int plen;
      plen = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
      frame = '1;
      frame[0] = 1'b0;
      x = 1'b0;
      for (int i = 0; i < nb; i++) begin
         frame[1+i] = d[i];
         x = x ^ d[i];
      end
      if (pm != 0) frame[1+nb] = (pm == 2) ? x : ~x;
      @(negedge clk);
      checks++;
      r = sel ? tx_ready6 : tx_ready0;
      if (r !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_ready: got %b want 1", name, r);
      end
      if (sel) begin tx_data6 = d[11:0]; tx_start6 = 1'b1; end
      else     begin tx_data0 = d[7:0];  tx_start0 = 1'b1; end
      bad = 0; rbad = 0; act = 1'b0;
      for (int j = 0; j < plen * BD; j++) begin
         @(negedge clk);
         if (j == 0 || (inject && j == 501)) begin tx_start0 = 1'b0; tx_start6 = 1'b0; end
         if (inject && j == 500) begin
            if (sel) begin tx_data6 = ~d[11:0]; tx_start6 = 1'b1; end
            else     begin tx_data0 = ~d[7:0];  tx_start0 = 1'b1; end
         end
         o = sel ? tx_out6 : tx_out0;
         r = sel ? tx_ready6 : tx_ready0;
         if (o !== frame[j/BD] && !bad) begin bad = 1; act = o; end
         if (r !== 1'b0) rbad = 1;
         if (j % BD == BD - 1) begin
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL %s bit%0d: tx_out got %b want %b", name, j/BD, act, frame[j/BD]);
            end
            bad = 0;
         end
      end
      checks++;
      if (rbad) begin
         errors++;
         $display("FAIL %s ready_low: tx_ready got 1 during frame want 0", name);
      end
      @(negedge clk);
      checks++;
      r = sel ? tx_ready6 : tx_ready0;
      o = sel ? tx_out6 : tx_out0;
      if (r !== 1'b1 || o !== 1'b1) begin
         errors++;
         $display("FAIL %s end: ready/out got %b%b want 11", name, r, o);
      end
      if (inject) begin
         repeat (3) @(negedge clk);
         checks++;
         r = sel ? tx_ready6 : tx_ready0;
         if (r !== 1'b1) begin
            errors++;
            $display("FAIL %s not_queued: tx_ready got %b want 1", name, r);
         end
      end
   endtask

   task automatic drive_rx(input logic [7:0] d, input logic par, input logic stop);
      rx0 = 1'b0;
      repeat (BD) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx0 = d[i];
         repeat (BD) @(posedge clk);
      end
      rx0 = par;
      repeat (BD) @(posedge clk);
      rx0 = stop;
      repeat (BD) @(posedge clk);
      rx0 = 1'b1;
   endtask

   task automatic check_rx(input string name, input int s0, input int dn, input logic [7:0] d,
                           input logic pe, input logic fe);
      repeat (4) @(negedge clk);
      checks++;
      if (strobes0 - s0 !== dn) begin
         errors++;
         $display("FAIL %s strobes: got %0d want %0d", name, strobes0 - s0, dn);
      end
      checks++;
      if (rx_data0 !== d || rx_perr0 !== pe || rx_ferr0 !== fe) begin
         errors++;
         $display("FAIL %s rx: data/perr/ferr got %h/%b/%b want %h/%b/%b",
                  name, rx_data0, rx_perr0, rx_ferr0, d, pe, fe);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; rst6 = 1'b1;
      tx_start0 = 1'b0; tx_data0 = '0; rx0 = 1'b1;
      tx_start6 = 1'b0; tx_data6 = '0; rx6 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_out0, tx_ready0, rx_new0, rx_perr0, rx_ferr0} !== 5'b11000 || rx_data0 !== 8'h00) begin
         errors++;
         $display("FAIL reset0: out/rdy/new/pe/fe got %b%b%b%b%b data %h want 11000 data 00",
                  tx_out0, tx_ready0, rx_new0, rx_perr0, rx_ferr0, rx_data0);
      end
      checks++;
      if ({tx_out6, tx_ready6, rx_new6} !== 3'b110 || rx_data6 !== 12'h000) begin
         errors++;
         $display("FAIL reset6: out/rdy/new got %b%b%b data %h want 110 data 000",
                  tx_out6, tx_ready6, rx_new6, rx_data6);
      end
      @(posedge clk); #1;
      rst = 1'b0; rst6 = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_tx_basic;
      tx_check(0, 16'h00A5, 8, 2, 1, 1'b1, "tx_a5");
   endtask

   task automatic test_rx_concurrent;
      int s0;
      s0 = strobes0;
      fork
         drive_rx(8'h3C, 1'b0, 1'b1);
         tx_check(0, 16'h00C3, 8, 2, 1, 1'b0, "tx_c3");
      join
      check_rx("rx_3c", s0, 1, 8'h3C, 1'b0, 1'b0);
   endtask

   task automatic test_parity_err;
      int s0;
      s0 = strobes0;
      drive_rx(8'h01, 1'b0, 1'b1);
      check_rx("rx_01_perr", s0, 1, 8'h01, 1'b1, 1'b0);
      s0 = strobes0;
      drive_rx(8'h03, 1'b0, 1'b1);
      check_rx("rx_03_clear", s0, 1, 8'h03, 1'b0, 1'b0);
   endtask

   task automatic test_break;
      int s0;
      s0 = strobes0;
      drive_rx(8'h55, 1'b0, 1'b0);
      rx0 = 1'b0;
      repeat (20 * BD) @(posedge clk);
      check_rx("rx_55_break", s0, 1, 8'h55, 1'b0, 1'b1);
      rx0 = 1'b1;
      repeat (2 * BD) @(posedge clk);
      s0 = strobes0;
      drive_rx(8'hAA, 1'b0, 1'b1);
      check_rx("rx_aa_after_break", s0, 1, 8'hAA, 1'b0, 1'b0);
   endtask

   task automatic test_glitch;
      int s0;
      s0 = strobes0;
      rx0 = 1'b0;
      repeat (30) @(posedge clk);
      rx0 = 1'b1;
      repeat (3 * BD) @(posedge clk);
      check_rx("rx_glitch", s0, 0, 8'hAA, 1'b0, 1'b0);
      s0 = strobes0;
      drive_rx(8'h7E, 1'b0, 1'b1);
      check_rx("rx_7e", s0, 1, 8'h7E, 1'b0, 1'b0);
   endtask

   task automatic test_cfg12;
      tx_check(1, 16'h04E6, 12, 1, 2, 1'b0, "tx_4e6");
   endtask

   task automatic test_reset_midframe;
      @(negedge clk);
      tx_data6 = 12'hA2C;
      tx_start6 = 1'b1;
      for (int j = 0; j < 5 * BD + 50; j++) begin
         @(negedge clk);
         if (j == 0) tx_start6 = 1'b0;
      end
      checks++;
      if (tx_out6 !== 1'b0 || tx_ready6 !== 1'b0) begin
         errors++;
         $display("FAIL midframe_bit4: out/ready got %b%b want 00", tx_out6, tx_ready6);
      end
      rst6 = 1'b1;
      #1;
      checks++;
      if (tx_out6 !== 1'b1 || tx_ready6 !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: out/ready got %b%b want 11", tx_out6, tx_ready6);
      end
      @(negedge clk);
      rst6 = 1'b0;
      repeat (2) @(negedge clk);
      tx_check(1, 16'h0135, 12, 1, 2, 1'b0, "tx_135_after_rst");
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_rx_concurrent();
      test_parity_err();
      test_break();
      test_glitch();
      test_cfg12();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
